// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the SPI boot loader.
//   loader_state_e : sequencer states
//   WORD_BYTES     : byte stride between consecutive ICCM words
//   CNT_W          : width of the word index / acknowledged-word counter
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    DONE,
    RUN,
    ERR
  } loader_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/boot_loader_fifo.sv
// Two-entry synchronous FIFO between the SPI word strobe and the sequencer.
//   clk_i, rst_ni : clock, async active-low reset (clears occupancy)
//   push, wdata   : write request and data
//   pop           : consume head entry (ignored when empty)
//   rdata         : head entry, valid whenever !empty
//   full, empty   : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module boot_loader_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_q];

  // When full, wr_q == rd_q: a simultaneous push overwrites the slot being popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/spi_boot_loader_ctrl.sv
// Boot sequencer: first SPI word is the program length N, the next N words are
// written to consecutive ICCM addresses over a single-outstanding write port.
// The core is held in reset until the load completes and en_i is seen in DONE.
//   clk_i, rst_ni          : clock, async active-low reset
//   en_i                   : run enable, sampled only in DONE
//   rx_word_i, rx_valid_i  : word strobe from the SPI deserializer
//   mem_req_o/addr/wdata   : ICCM write request (held until mem_gnt_i)
//   mem_gnt_i/ack_i/err_i  : grant, response, response error
//   core_rst_no            : core reset, active-low
//   load_done_o, err_o     : load complete, sticky error
//   word_cnt_o             : words acknowledged so far
module spi_boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] rx_word_i,
  input  logic                  rx_valid_i,
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_ack_i,
  input  logic                  mem_err_i,
  output logic                  core_rst_no,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [15:0]           word_cnt_o
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  loader_state_e         state_q, state_d;
  logic                  req_q, req_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  core_q, core_d;

  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push_c, pop_c, ovf_c, ack_take_c;
  logic [CNT_W-1:0]      cnt_inc_c;

  // Words arriving after the load phase are dropped silently.
  assign push_c = rx_valid_i &
                  ((state_q == IDLE) | (state_q == LOAD) | (state_q == WAIT_ACK));
  assign pop_c  = ~fifo_empty &
                  ((state_q == IDLE) | ((state_q == LOAD) & ~req_q));
  assign ovf_c  = push_c & fifo_full & ~pop_c;
  // A response arriving with the grant is taken immediately.
  assign ack_take_c = mem_ack_i &
                      ((state_q == WAIT_ACK) | ((state_q == LOAD) & req_q & mem_gnt_i));
  assign cnt_inc_c  = cnt_q + CNT_W'(1);

  boot_loader_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push_c),
    .wdata (rx_word_i),
    .pop   (pop_c),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    done_d  = done_q;
    err_d   = err_q;
    core_d  = (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (32'(fifo_head) == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (32'(fifo_head) > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
            len_d   = CNT_W'(fifo_head);
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        if (req_q) begin
          if (mem_gnt_i) begin
            req_d   = 1'b0;
            tmr_d   = '0;
            state_d = WAIT_ACK;
          end
        end else if (!fifo_empty) begin
          req_d   = 1'b1;
          addr_d  = BASE_ADDR + 32'(cnt_q) * 32'(WORD_BYTES);
          wdata_d = fifo_head;
        end
      end
      WAIT_ACK: begin
        if (!mem_ack_i) begin
          if (tmr_q == TMR_W'(ACK_TIMEOUT)) state_d = ERR;
          else                              tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      DONE: begin
        if (en_i) state_d = RUN;
      end
      default: ;
    endcase

    if (ack_take_c) begin
      if (mem_err_i) begin
        state_d = ERR;
      end else begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
    end

    if (ovf_c) state_d = ERR;

    if (state_d == ERR) begin
      err_d  = 1'b1;
      req_d  = 1'b0;
      done_d = 1'b0;
      core_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      core_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      core_q  <= core_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_rst_no = core_q;
  assign load_done_o = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_spi_boot_loader_ctrl.sv
// Directed bench for spi_boot_loader_ctrl with a small ICCM responder model.
module tb_spi_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] rx_word = '0;
  logic        rx_valid = 1'b0;
  bit          mem_gnt, mem_ack, mem_err;

  logic        mem_req_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        core_rst_no, load_done, err;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;

  // responder configuration (written by tests) and observations (written by responder)
  int gnt_delay = 0;
  int ack_delay = 1;
  int err_ack_idx = -1;
  bit ack_hold = 1'b0;
  int wr_n, req_cyc, ack_num, req_wait, ack_wait;
  bit ack_pend, stall_bad;
  logic [31:0] hold_addr, hold_data;
  logic [31:0] log_addr [16];
  logic [31:0] log_data [16];

  always #5 clk = ~clk;

  spi_boot_loader_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .rx_word_i  (rx_word),
    .rx_valid_i (rx_valid),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i  (mem_gnt),
    .mem_ack_i  (mem_ack),
    .mem_err_i  (mem_err),
    .core_rst_no(core_rst_no),
    .load_done_o(load_done),
    .err_o      (err),
    .word_cnt_o (word_cnt)
  );

  // ICCM responder: grant after gnt_delay cycles, ack after ack_delay cycles.
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    if (!rst_n) begin
      wr_n = 0; req_cyc = 0; ack_num = 0; req_wait = 0; ack_wait = 0;
      ack_pend = 1'b0; stall_bad = 1'b0;
    end else begin
      if (ack_pend) begin
        if (ack_wait >= ack_delay && !ack_hold) begin
          mem_ack = 1'b1; mem_err = (ack_num == err_ack_idx);
          ack_num++; ack_pend = 1'b0;
        end else ack_wait++;
      end
      if (mem_req_o) begin
        req_cyc++;
        if (ack_pend) stall_bad = 1'b1;
        if (req_wait == 0) begin
          hold_addr = mem_addr_o; hold_data = mem_wdata_o;
        end else if (mem_addr_o !== hold_addr || mem_wdata_o !== hold_data) stall_bad = 1'b1;
        if (req_wait >= gnt_delay) begin
          mem_gnt = 1'b1;
          if (wr_n < 16) begin log_addr[wr_n] = mem_addr_o; log_data[wr_n] = mem_wdata_o; end
          wr_n++; req_wait = 0; ack_pend = 1'b1; ack_wait = 1;
          if (ack_delay == 0 && !ack_hold) begin
            mem_ack = 1'b1; mem_err = (ack_num == err_ack_idx);
            ack_num++; ack_pend = 1'b0;
          end
        end else req_wait++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; rx_valid = 1'b0; rx_word = '0;
    gnt_delay = 0; ack_delay = 1; ack_hold = 1'b0; err_ack_idx = -1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    rx_word = w; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_end(input int budget, input string tag);
    int k = 0;
    while (!load_done && !err && k < budget) begin tick(1); k++; end
    checks++;
    if (!(load_done || err)) begin
      errors++;
      $display("FAIL %s_timeout: done=%b err=%b after %0d cycles, required done or err", tag, load_done, err, k);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({mem_req_o, core_rst_no, load_done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000", {mem_req_o, core_rst_no, load_done, err});
    end
    do_reset;
    checks++;
    if (word_cnt !== 16'd0 || mem_addr_o !== 32'd0) begin
      errors++; $display("FAIL reset_regs: cnt=%0d addr=%h required 0/0", word_cnt, mem_addr_o);
    end
  endtask

  task automatic test_load3;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA0A0_0000; exp_d[1] = 32'hA1A1_1111; exp_d[2] = 32'hA2A2_2222;
    do_reset;
    send_word(32'd3);
    send_word(exp_d[0]);
    en = 1'b1; tick(1); en = 1'b0;
    send_word(exp_d[1]);
    send_word(exp_d[2]);
    wait_end(100, "load3");
    checks++;
    if (wr_n !== 3 || stall_bad) begin
      errors++; $display("FAIL load3_writes: got %0d writes (stall_bad=%b) required 3", wr_n, stall_bad);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_addr[i] !== 32'(i * 4) || log_data[i] !== exp_d[i]) begin
        errors++; $display("FAIL load3_word%0d: got addr=%h data=%h required addr=%h data=%h",
                           i, log_addr[i], log_data[i], 32'(i * 4), exp_d[i]);
      end
    end
    checks++;
    if (word_cnt !== 16'd3 || load_done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL load3_status: cnt=%0d done=%b err=%b required 3/1/0", word_cnt, load_done, err);
    end
    tick(5);
    checks++;
    if (core_rst_no !== 1'b0) begin
      errors++; $display("FAIL load3_hold: core_rst_no=%b required 0 (en pulse before DONE)", core_rst_no);
    end
    en = 1'b1;
    tick(1);
    checks++;
    if (core_rst_no !== 1'b0) begin
      errors++; $display("FAIL load3_run_entry: core_rst_no=%b required 0", core_rst_no);
    end
    tick(1);
    checks++;
    if (core_rst_no !== 1'b1) begin
      errors++; $display("FAIL load3_release: core_rst_no=%b required 1", core_rst_no);
    end
    send_word(32'hDEAD_BEEF);
    checks++;
    if (err !== 1'b0 || core_rst_no !== 1'b1 || wr_n !== 3) begin
      errors++; $display("FAIL load3_rx_in_run: err=%b core=%b writes=%0d required 0/1/3", err, core_rst_no, wr_n);
    end
  endtask

  task automatic test_len_zero;
    do_reset;
    send_word(32'd0);
    checks++;
    if (load_done !== 1'b1 || word_cnt !== 16'd0 || req_cyc !== 0) begin
      errors++; $display("FAIL zero_done: done=%b cnt=%0d req_cycles=%0d required 1/0/0", load_done, word_cnt, req_cyc);
    end
    en = 1'b1;
    tick(2);
    checks++;
    if (core_rst_no !== 1'b1) begin
      errors++; $display("FAIL zero_release: core_rst_no=%b required 1", core_rst_no);
    end
  endtask

  task automatic test_length_bounds;
    do_reset;
    send_word(32'd4097);
    en = 1'b1;
    tick(10);
    checks++;
    if (err !== 1'b1 || load_done !== 1'b0 || core_rst_no !== 1'b0 || req_cyc !== 0) begin
      errors++; $display("FAIL too_long: err=%b done=%b core=%b req_cycles=%0d required 1/0/0/0",
                         err, load_done, core_rst_no, req_cyc);
    end
    do_reset;
    send_word(32'd4096);
    send_word(32'h1234_5678);
    tick(6);
    checks++;
    if (err !== 1'b0 || wr_n !== 1 || log_addr[0] !== 32'd0 || log_data[0] !== 32'h1234_5678 || word_cnt !== 16'd1) begin
      errors++; $display("FAIL max_len_accepted: err=%b writes=%0d addr=%h data=%h cnt=%0d required 0/1/0/12345678/1",
                         err, wr_n, log_addr[0], log_data[0], word_cnt);
    end
  endtask

  task automatic test_gnt_stall;
    int k = 0;
    do_reset;
    gnt_delay = 5;
    send_word(32'd2);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_end(200, "stall");
    checks++;
    if (load_done !== 1'b1 || wr_n !== 2 || req_cyc !== 12 || stall_bad) begin
      errors++; $display("FAIL stall_writes: done=%b writes=%0d req_cycles=%0d unstable=%b required 1/2/12/0",
                         load_done, wr_n, req_cyc, stall_bad);
    end
    checks++;
    if (log_addr[1] !== 32'h4 || log_data[1] !== 32'h2222_2222) begin
      errors++; $display("FAIL stall_word1: addr=%h data=%h required 4/22222222", log_addr[1], log_data[1]);
    end
    // overflow: three pushes while the first write is stalled
    do_reset;
    gnt_delay = 20;
    send_word(32'd3);
    send_word(32'h3333_3333);
    while (!mem_req_o && k < 50) begin tick(1); k++; end
    checks++;
    if (!mem_req_o) begin
      errors++; $display("FAIL ovf_req_timeout: mem_req_o=%b required 1", mem_req_o);
    end
    rx_word = 32'h4444_4444; rx_valid = 1'b1; tick(1);
    rx_word = 32'h5555_5555; tick(1);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL ovf_early: err=%b after two pushes, required 0", err);
    end
    rx_word = 32'h6666_6666; tick(1);
    rx_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL ovf_third: err=%b req=%b required 1/0", err, mem_req_o);
    end
    tick(25);
    checks++;
    if (wr_n !== 0 || core_rst_no !== 1'b0) begin
      errors++; $display("FAIL ovf_after: writes=%0d core=%b required 0/0", wr_n, core_rst_no);
    end
  endtask

  task automatic test_ack_err;
    do_reset;
    err_ack_idx = 1;
    send_word(32'd3);
    send_word(32'hC0);
    send_word(32'hC1);
    send_word(32'hC2);
    wait_end(100, "ack_err");
    checks++;
    if (err !== 1'b1 || word_cnt !== 16'd1 || wr_n !== 2 || load_done !== 1'b0 || core_rst_no !== 1'b0) begin
      errors++; $display("FAIL ack_err: err=%b cnt=%0d writes=%0d done=%b core=%b required 1/1/2/0/0",
                         err, word_cnt, wr_n, load_done, core_rst_no);
    end
  endtask

  task automatic test_timeout;
    int k = 0;
    do_reset;
    ack_hold = 1'b1;
    send_word(32'd1);
    send_word(32'h7777_7777);
    while (wr_n < 1 && k < 50) begin tick(1); k++; end
    tick(200);
    checks++;
    if (err !== 1'b0 || wr_n !== 1) begin
      errors++; $display("FAIL timeout_early: err=%b writes=%0d required 0/1", err, wr_n);
    end
    tick(100);
    checks++;
    if (err !== 1'b1 || word_cnt !== 16'd0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL timeout: err=%b cnt=%0d req=%b required 1/0/0", err, word_cnt, mem_req_o);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    ack_delay = 0;
    rx_valid = 1'b1;
    rx_word = 32'd2;         tick(1);
    rx_word = 32'hB0B0_B0B0; tick(1);
    rx_word = 32'hB1B1_B1B1; tick(1);
    rx_valid = 1'b0;
    wait_end(50, "b2b");
    checks++;
    if (load_done !== 1'b1 || err !== 1'b0 || word_cnt !== 16'd2 || wr_n !== 2 || log_data[1] !== 32'hB1B1_B1B1) begin
      errors++; $display("FAIL b2b: done=%b err=%b cnt=%0d writes=%0d data1=%h required 1/0/2/2/b1b1b1b1",
                         load_done, err, word_cnt, wr_n, log_data[1]);
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    do_reset;
    send_word(32'd4);
    send_word(32'hC0C0_0000);
    send_word(32'hC1C1_0000);
    while (word_cnt !== 16'd2 && k < 50) begin tick(1); k++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (word_cnt !== 16'd0 || mem_req_o !== 1'b0 || load_done !== 1'b0 || core_rst_no !== 1'b0) begin
      errors++; $display("FAIL mid_reset: cnt=%0d req=%b done=%b core=%b required 0/0/0/0",
                         word_cnt, mem_req_o, load_done, core_rst_no);
    end
    do_reset;
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(32'hD000_0000 + 32'(i));
    wait_end(150, "reload");
    checks++;
    if (load_done !== 1'b1 || err !== 1'b0 || word_cnt !== 16'd4 || wr_n !== 4) begin
      errors++; $display("FAIL reload: done=%b err=%b cnt=%0d writes=%0d required 1/0/4/4", load_done, err, word_cnt, wr_n);
    end
    checks++;
    if (log_addr[3] !== 32'hC || log_data[0] !== 32'hD000_0000 || log_data[3] !== 32'hD000_0003) begin
      errors++; $display("FAIL reload_words: addr3=%h data0=%h data3=%h required c/d0000000/d0000003",
                         log_addr[3], log_data[0], log_data[3]);
    end
  endtask

  initial begin
    test_reset;
    test_load3;
    test_len_zero;
    test_length_bounds;
    test_gnt_stall;
    test_ack_err;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
